// File: rtl/uart_frame_tx_pkg.sv
// Shared types and constants for the UART frame sender.
// Holds the FSM encoding, the fixed per-frame overhead and the default sync byte.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } frame_state_t;

  // SYNC + LEN + CHK surround the payload.
  localparam int         FRAME_OVERHEAD    = 3;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_tx_if.sv
// Load/payload and UART_TX byte-handshake bundle; slave = frame sender, master = its neighbours.
// Signal names keep the frame sender's own direction prefixes.
interface uart_frame_tx_if #(
  parameter int PAYLOAD_BYTES = 32
);

  logic                       i_Load;
  logic [8*PAYLOAD_BYTES-1:0] i_Payload;
  logic                       o_Ready;
  logic                       o_TX_DV;
  logic [7:0]                 o_TX_Byte;
  logic                       i_TX_Active;
  logic                       i_TX_Done;
  logic                       o_Frame_Done;
  logic                       o_Error;

  modport master (
    output i_Load, i_Payload, i_TX_Active, i_TX_Done,
    input  o_Ready, o_TX_DV, o_TX_Byte, o_Frame_Done, o_Error
  );

  modport slave (
    input  i_Load, i_Payload, i_TX_Active, i_TX_Done,
    output o_Ready, o_TX_DV, o_TX_Byte, o_Frame_Done, o_Error
  );

endinterface

// File: rtl/uart_frame_tx_watchdog.sv
// Clear/enable up-counter; o_Expired is high while enabled at count TIMEOUT_CLKS-1.
// Zero latency from count to flag; the counter parks at the terminal value.
module uart_tx_watchdog #(
  parameter int TIMEOUT_CLKS = 6000
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  localparam int               CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      r_count <= '0;
    end else if (i_Enable && (r_count != TERM)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_Expired = i_Enable && (r_count == TERM);

endmodule

// File: rtl/uart_frame_tx.sv
// Frame sender for UART_TX: SYNC, LEN, payload MSB-first, XOR CHK; all outputs registered.
// Strobes one cycle after load/done when UART is idle, holds while i_TX_Active, aborts on watchdog.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 32,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS  = 6000
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  uart_frame_tx_if.slave  io_frame
);

  localparam int               NUM_BYTES = PAYLOAD_BYTES + FRAME_OVERHEAD;
  localparam int               IDX_W     = $clog2(NUM_BYTES);
  localparam int               PL_W      = 8 * PAYLOAD_BYTES;
  localparam logic [IDX_W-1:0] LEN_IDX   = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [7:0]       LEN_BYTE  = 8'(PAYLOAD_BYTES);

  frame_state_t     r_state;
  frame_state_t     w_state_nxt;
  logic [PL_W-1:0]  r_shift;
  logic [7:0]       r_chk;
  logic [IDX_W-1:0] r_idx;
  logic             r_ready;
  logic             r_tx_dv;
  logic [7:0]       r_tx_byte;
  logic             r_frame_done;
  logic             r_error;

  logic [7:0]       w_byte;
  logic             w_is_payload;
  logic             w_load;
  logic             w_issue;
  logic             w_advance;
  logic             w_finish;
  logic             w_abort;
  logic             w_wd_en;
  logic             w_wd_expired;

  // Byte for the current index; payload always comes from the top of the shifter.
  always_comb begin
    w_is_payload = (r_idx != '0) && (r_idx != LEN_IDX) && (r_idx != LAST_IDX);
    if (r_idx == '0) begin
      w_byte = SYNC_BYTE;
    end else if (r_idx == LEN_IDX) begin
      w_byte = LEN_BYTE;
    end else if (r_idx == LAST_IDX) begin
      w_byte = r_chk;
    end else begin
      w_byte = r_shift[PL_W-1 -: 8];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (io_frame.i_Load) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!io_frame.i_TX_Active) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (io_frame.i_TX_Done) begin
          if (r_idx == LAST_IDX) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ISSUE;
          end
        end else if (w_wd_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_shift      <= '0;
      r_chk        <= '0;
      r_idx        <= '0;
      r_ready      <= 1'b1;
      r_tx_dv      <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_ready      <= (w_state_nxt == IDLE);
      r_tx_dv      <= w_issue;
      r_frame_done <= w_finish;
      r_error      <= w_abort;
      if (w_load) begin
        r_shift <= io_frame.i_Payload;
        r_chk   <= '0;
        r_idx   <= '0;
      end
      if (w_issue) begin
        r_tx_byte <= w_byte;
        // SYNC and the checksum itself stay out of the running XOR.
        if ((r_idx != '0) && (r_idx != LAST_IDX)) begin
          r_chk <= r_chk ^ w_byte;
        end
        if (w_is_payload) begin
          r_shift <= r_shift << 8;
        end
      end
      if (w_advance) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign w_wd_en = (r_state == WAIT_DONE);

  uart_tx_watchdog #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_watchdog (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (w_issue),
    .i_Enable  (w_wd_en),
    .o_Expired (w_wd_expired)
  );

  assign io_frame.o_Ready      = r_ready;
  assign io_frame.o_TX_DV      = r_tx_dv;
  assign io_frame.o_TX_Byte    = r_tx_byte;
  assign io_frame.o_Frame_Done = r_frame_done;
  assign io_frame.o_Error      = r_error;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench: frame sender driving a behavioural UART_TX plus serial decoder, and a second copy on a never-done stub.
// Expected frames come from a queue-based model of SYNC/LEN/payload/XOR.
`timescale 1ns/1ps
module tb_uart_frame_tx;

  localparam int PB      = 4;
  localparam int CPB     = 16;
  localparam int BIT_GAP = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_frame_tx_if #(.PAYLOAD_BYTES(PB)) fbus();
  uart_frame_tx_if #(.PAYLOAD_BYTES(PB)) sbus();

  uart_frame_tx #(.PAYLOAD_BYTES(PB), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(400)) u_dut (
    .i_Clock  (clk),
    .i_Reset  (rst),
    .io_frame (fbus.slave)
  );

  uart_frame_tx #(.PAYLOAD_BYTES(PB), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(100)) u_dut_stub (
    .i_Clock  (clk),
    .i_Reset  (rst),
    .io_frame (sbus.slave)
  );

  initial forever #10 clk = ~clk;

  // Behavioural UART_TX: start, 8 data LSB-first, stop; done+inactive at end of stop.
  logic       tx_active = 1'b0;
  logic       tx_done   = 1'b0;
  logic       tx_serial = 1'b1;
  logic [9:0] u_frame   = '1;
  int         u_cnt     = 0;
  int         u_bit     = 0;

  assign fbus.i_TX_Active = tx_active;
  assign fbus.i_TX_Done   = tx_done;
  assign sbus.i_TX_Active = 1'b0;
  assign sbus.i_TX_Done   = 1'b0;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (!tx_active) begin
      if (fbus.o_TX_DV === 1'b1) begin
        tx_active <= 1'b1;
        u_frame   <= {1'b1, fbus.o_TX_Byte, 1'b0};
        u_cnt     <= 0;
        u_bit     <= 0;
        tx_serial <= 1'b0;
      end
    end else if (u_cnt < CPB - 1) begin
      u_cnt <= u_cnt + 1;
    end else begin
      u_cnt <= 0;
      if (u_bit == 9) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        tx_serial <= 1'b1;
      end else begin
        u_bit     <= u_bit + 1;
        tx_serial <= u_frame[u_bit + 1];
      end
    end
  end

  // Serial decoder: mid-bit sampling of the line.
  logic [7:0] rx_q[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_serial);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx_serial;
      end
      repeat (CPB) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  // Monitor: counts events and protocol violations; the main sequence checks them.
  int   cyc = 0, dv_count = 0, fd_count = 0, err_count = 0;
  int   last_dv_cyc = -100000, last_done_cyc = 0, fd_cyc = 0;
  int   gap_viol = 0, width_viol = 0, active_viol = 0, overlap_viol = 0;
  int   sdv_count = 0, sdv_cyc = 0, serr_count = 0, serr_cyc = 0, sfd_count = 0;
  logic prev_dv = 1'b0, outstanding = 1'b0, ready_at_fd = 1'b0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (fbus.o_TX_DV === 1'b1) begin
      dv_count++;
      if (prev_dv) width_viol++;
      if (tx_active) active_viol++;
      if (outstanding) overlap_viol++;
      if (cyc - last_dv_cyc < BIT_GAP) gap_viol++;
      last_dv_cyc = cyc;
      outstanding = 1'b1;
    end
    if (tx_done) begin
      outstanding   = 1'b0;
      last_done_cyc = cyc;
    end
    prev_dv = (fbus.o_TX_DV === 1'b1);
    if (fbus.o_Frame_Done === 1'b1) begin
      fd_count++;
      fd_cyc      = cyc;
      ready_at_fd = fbus.o_Ready;
    end
    if (fbus.o_Error === 1'b1) err_count++;
    if (sbus.o_TX_DV === 1'b1) begin
      if (sdv_count == 0) sdv_cyc = cyc;
      sdv_count++;
    end
    if (sbus.o_Error === 1'b1) begin
      if (serr_count == 0) serr_cyc = cyc;
      serr_count++;
    end
    if (sbus.o_Frame_Done === 1'b1) sfd_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  logic [7:0] exp_q[$];
  task automatic model_frame(input logic [31:0] p);
    logic [7:0] c;
    logic [7:0] b;
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(PB));
    c = 8'(PB);
    for (int i = PB - 1; i >= 0; i--) begin
      b = p[8*i +: 8];
      c = c ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(c);
  endtask

  task automatic load_f(input logic [31:0] p);
    fbus.i_Payload = p;
    fbus.i_Load    = 1'b1;
    tick(1);
    fbus.i_Load    = 1'b0;
  endtask

  int f_dv_base = 0, f_fd_base = 0;
  task automatic start_frame(input logic [31:0] p);
    f_dv_base = dv_count;
    f_fd_base = fd_count;
    rx_q      = {};
    model_frame(p);
    load_f(p);
  endtask

  task automatic finish_frame(input string tag);
    int         n;
    logic [31:0] obs;
    n = 0;
    while (fd_count < f_fd_base + 1 && n < 12 * BIT_GAP) begin
      tick(1);
      n++;
    end
    chk({tag, "_frame_done_seen"}, 32'(fd_count - f_fd_base), 1);
    chk({tag, "_dv_pulses"}, 32'(dv_count - f_dv_base), PB + 3);
    chk({tag, "_fd_latency"}, 32'((fd_cyc - last_done_cyc) inside {[1:2]}), 1);
    chk({tag, "_ready_at_fd"}, 32'(ready_at_fd), 1);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
    end
  endtask

  initial begin
    int          n;
    int          nrl;
    int          base;
    logic [31:0] p;

    fbus.i_Load    = 1'b0;
    fbus.i_Payload = '0;
    sbus.i_Load    = 1'b0;
    sbus.i_Payload = '0;
    tick(3);
    chk("rst_ready", 32'(fbus.o_Ready), 1);
    chk("rst_dv", 32'(fbus.o_TX_DV), 0);
    chk("rst_byte", 32'(fbus.o_TX_Byte), 0);
    chk("rst_frame_done", 32'(fbus.o_Frame_Done), 0);
    chk("rst_error", 32'(fbus.o_Error), 0);
    chk("rst_stub_ready", 32'(sbus.o_Ready), 1);
    rst = 1'b0;
    tick(2);

    // Basic frame with a load pulse mid-frame that must be ignored.
    start_frame(32'hDEADBEEF);
    n = 0;
    while (dv_count < f_dv_base + 3 && n < 4 * BIT_GAP) begin
      tick(1);
      n++;
    end
    chk("busy_reach_byte3", 32'(dv_count >= f_dv_base + 3), 1);
    chk("busy_ready_low", 32'(fbus.o_Ready), 0);
    load_f(32'h01020304);
    finish_frame("basic");
    chk("basic_chk_const", (rx_q.size() == 7) ? 32'(rx_q[6]) : 32'hFFFF_FFFF, 32'h26);
    base = dv_count;
    tick(2 * BIT_GAP);
    chk("busy_load_not_queued", 32'(dv_count - base), 0);
    chk("idle_ready", 32'(fbus.o_Ready), 1);

    start_frame(32'h01020304);
    finish_frame("second");
    chk("second_chk_const", (rx_q.size() == 7) ? 32'(rx_q[6]) : 32'hFFFF_FFFF, 32'h00);

    for (int k = 0; k < 4; k++) begin
      p = $urandom;
      tick(1 + $urandom_range(0, 5));
      start_frame(p);
      finish_frame($sformatf("rand%0d", k));
    end

    chk("no_error_pulses", 32'(err_count), 0);
    chk("strobe_gap_viol", 32'(gap_viol), 0);
    chk("strobe_width_viol", 32'(width_viol), 0);
    chk("strobe_while_active", 32'(active_viol), 0);
    chk("strobe_before_done", 32'(overlap_viol), 0);

    // Watchdog on the never-done stub.
    sbus.i_Payload = $urandom;
    sbus.i_Load    = 1'b1;
    tick(1);
    sbus.i_Load    = 1'b0;
    n = 0;
    while (serr_count < 1 && n < 400) begin
      tick(1);
      n++;
    end
    chk("to_error_seen", 32'(serr_count), 1);
    chk("to_error_delay", 32'(serr_cyc - sdv_cyc), 100);
    tick(1);
    chk("to_ready_after", 32'(sbus.o_Ready), 1);
    chk("to_single_strobe", 32'(sdv_count), 1);
    chk("to_no_frame_done", 32'(sfd_count), 0);

    // Reset while byte 3 is on the wire.
    start_frame(32'h11223344);
    n = 0;
    while (dv_count < f_dv_base + 3 && n < 4 * BIT_GAP) begin
      tick(1);
      n++;
    end
    chk("mrst_reach_byte3", 32'(dv_count >= f_dv_base + 3), 1);
    tick(3 * CPB);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_ready", 32'(fbus.o_Ready), 1);
    chk("mrst_dv", 32'(fbus.o_TX_DV), 0);
    chk("mrst_byte", 32'(fbus.o_TX_Byte), 0);
    chk("mrst_frame_done", 32'(fbus.o_Frame_Done), 0);
    chk("mrst_error", 32'(fbus.o_Error), 0);
    start_frame(32'h00000000);
    n = 0;
    while (tx_active && n < 2 * BIT_GAP) begin
      tick(1);
      n++;
    end
    chk("mrst_active_fell", 32'(tx_active), 0);
    chk("mrst_no_early_strobe", 32'(dv_count - f_dv_base), 0);
    rx_q = {};
    finish_frame("after_rst");
    chk("after_rst_strobe_while_active", 32'(active_viol), 0);

    // Reset and load in the same cycle: load dropped.
    tick(5);
    rst            = 1'b1;
    fbus.i_Load    = 1'b1;
    fbus.i_Payload = $urandom;
    tick(1);
    rst         = 1'b0;
    fbus.i_Load = 1'b0;
    base = dv_count;
    nrl  = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (fbus.o_Ready !== 1'b1) nrl++;
    end
    chk("coll_no_strobe", 32'(dv_count - base), 0);
    chk("coll_ready_held", 32'(nrl), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
